// File: rtl/measure_unit_pkg.sv
// measure_unit_pkg: shared scan FSM states, default widths and the per-step result record
package measure_unit_pkg;
  localparam int CODE_W_DEF = 16;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DAC_WR,
    S_DAC_BUSY,
    S_SETTLE,
    S_STB,
    S_EMIT,
    S_NEXT
  } scan_state_e;
  typedef struct packed {
    logic [CODE_W_DEF-1:0] code;
    logic [CNT_W_DEF-1:0] hits;
  } scan_result_t;
endpackage

// File: rtl/threshold_scan_ctl.sv
// threshold_scan_ctl: steps a DAC threshold, settles, counts comparator hits per step and emits {code, hits}
module threshold_scan_ctl
  import measure_unit_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SETTLE_CYCLES = 64,
  parameter int STB_TIMEOUT = 2**20
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CODE_W-1:0] code_start_i,
  input  logic [CODE_W-1:0] code_stop_i,
  input  logic [CODE_W-1:0] code_step_i,
  input  logic [CNT_W-1:0]  samples_i,
  output logic [CODE_W-1:0] dac_code_o,
  output logic              dac_wre_o,
  input  logic              dac1_rdy_i,
  input  logic              dac2_rdy_i,
  output logic              stb_req_o,
  input  logic              stb_valid_i,
  input  logic              cmp_out_i,
  output logic              res_valid_o,
  input  logic              res_rdy_i,
  output logic [CODE_W-1:0] res_code_o,
  output logic [CNT_W-1:0]  res_hits_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  scan_state_e r_state, w_state_nx;
  logic [CODE_W-1:0] r_code, r_stop, r_step, r_dac_code;
  logic [CNT_W-1:0] r_samples, r_n, r_hits, w_n_inc;
  logic [31:0] r_cyc;
  logic [CODE_W:0] w_next;
  logic r_wre, r_done, r_err, r_gap, r_seen_low;
  logic w_bad, w_rdy, w_go, w_stb_hit, w_last, w_timeout, w_finish, w_settled;
  assign w_bad = code_step_i == '0 || samples_i == '0 || code_start_i > code_stop_i;
  assign w_rdy = dac1_rdy_i && dac2_rdy_i;
  assign w_go = !abort_i;
  assign stb_req_o = r_state == S_STB && !r_gap;
  assign w_stb_hit = stb_req_o && stb_valid_i;
  assign w_n_inc = r_n + 1'b1;
  assign w_last = w_stb_hit && w_n_inc == r_samples;
  assign w_timeout = STB_TIMEOUT != 0 && stb_req_o && !stb_valid_i && r_cyc + 32'd1 == 32'(STB_TIMEOUT);
  assign w_settled = r_cyc + 32'd1 >= 32'(SETTLE_CYCLES);
  assign w_next = {1'b0, r_code} + {1'b0, r_step};
  assign w_finish = w_next[CODE_W] || w_next[CODE_W-1:0] > r_stop;
  assign dac_code_o = r_dac_code;
  assign dac_wre_o = r_wre;
  assign res_valid_o = r_state == S_EMIT;
  assign res_code_o = r_code;
  assign res_hits_o = r_hits;
  assign busy_o = r_state != S_IDLE;
  assign done_o = r_done;
  assign err_o = r_err;
  always_ff @(posedge wb_clk_i) r_state <= wb_rst_i ? S_IDLE : w_state_nx;
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:     w_state_nx = start_i && !w_bad ? S_DAC_WR : S_IDLE;
      S_DAC_WR:   w_state_nx = w_rdy ? S_DAC_BUSY : S_DAC_WR;
      S_DAC_BUSY: w_state_nx = r_seen_low && w_rdy ? S_SETTLE : S_DAC_BUSY;
      S_SETTLE:   w_state_nx = w_settled ? S_STB : S_SETTLE;
      S_STB:      w_state_nx = w_timeout ? S_IDLE : w_last ? S_EMIT : S_STB;
      S_EMIT:     w_state_nx = res_rdy_i ? S_NEXT : S_EMIT;
      S_NEXT:     w_state_nx = w_finish ? S_IDLE : S_DAC_WR;
      default:    w_state_nx = S_IDLE;
    endcase
    if (abort_i && r_state != S_IDLE) w_state_nx = S_IDLE;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_code <= '0;
      r_stop <= '0;
      r_step <= '0;
      r_samples <= '0;
      r_dac_code <= '0;
      r_n <= '0;
      r_hits <= '0;
      r_cyc <= '0;
      r_wre <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_gap <= 1'b0;
      r_seen_low <= 1'b0;
    end else begin
      r_wre <= w_go && r_state == S_DAC_WR && w_rdy;
      r_done <= w_go && r_state == S_NEXT && w_finish;
      r_gap <= w_stb_hit;
      r_seen_low <= r_state == S_DAC_BUSY && (r_seen_low || !w_rdy);
      r_cyc <= w_state_nx != r_state ? '0 : (r_state == S_SETTLE || (stb_req_o && !stb_valid_i)) ? r_cyc + 32'd1 : '0;
      if (r_state == S_IDLE && start_i) begin
        r_err <= w_bad;
        if (!w_bad) begin
          r_code <= code_start_i;
          r_stop <= code_stop_i;
          r_step <= code_step_i;
          r_samples <= samples_i;
        end
      end
      if (w_go && w_timeout) r_err <= 1'b1;
      if (w_go && r_state == S_DAC_WR && w_rdy) r_dac_code <= r_code;
      if (r_state == S_SETTLE) begin
        r_hits <= '0;
        r_n <= '0;
      end
      if (w_stb_hit) begin
        r_hits <= r_hits + CNT_W'(cmp_out_i);
        r_n <= w_n_inc;
      end
      if (w_go && r_state == S_NEXT && !w_finish) r_code <= w_next[CODE_W-1:0];
    end
  end
endmodule

// File: tb/tb_threshold_scan_ctl.sv
// tb_threshold_scan_ctl: directed sweeps against DAC and strobe-generator models with hand-computed results
module tb_threshold_scan_ctl;
  import measure_unit_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, res_rdy = 1'b1, stb_en = 1'b1;
  logic [15:0] code_start = '0, code_stop = '0, code_step = '0, samples = '0;
  logic [15:0] dac_code, res_code, res_hits;
  logic dac_wre, stb_req, stb_valid, cmp_out, res_valid, busy, done, err, dac_rdy;
  logic [2:0] dac_cnt;
  logic [7:0] k;
  int checks = 0, errors = 0, n_done = 0, n_wre = 0;
  scan_result_t q[$];
  always #5 clk = ~clk;
  threshold_scan_ctl #(.CODE_W(16), .CNT_W(16), .SETTLE_CYCLES(4), .STB_TIMEOUT(100)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort),
    .code_start_i(code_start), .code_stop_i(code_stop), .code_step_i(code_step), .samples_i(samples),
    .dac_code_o(dac_code), .dac_wre_o(dac_wre), .dac1_rdy_i(dac_rdy), .dac2_rdy_i(dac_rdy),
    .stb_req_o(stb_req), .stb_valid_i(stb_valid), .cmp_out_i(cmp_out),
    .res_valid_o(res_valid), .res_rdy_i(res_rdy), .res_code_o(res_code), .res_hits_o(res_hits),
    .busy_o(busy), .done_o(done), .err_o(err)
  );
  assign dac_rdy = dac_cnt == 3'd0;
  assign cmp_out = k[0];
  always @(posedge clk) begin
    if (rst) dac_cnt <= '0;
    else if (dac_wre) dac_cnt <= 3'd3;
    else if (dac_cnt != 3'd0) dac_cnt <= dac_cnt - 3'd1;
  end
  always @(posedge clk) begin
    if (rst) begin
      stb_valid <= 1'b0;
      k <= '0;
    end else begin
      stb_valid <= stb_req && !stb_valid && stb_en;
      if (stb_valid) k <= k + 8'd1;
    end
  end
  always @(negedge clk) begin
    if (done) n_done++;
    if (dac_wre) n_wre++;
    if (res_valid && res_rdy) q.push_back('{code: res_code, hits: res_hits});
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic sweep(input logic [15:0] cs, input logic [15:0] ce, input logic [15:0] st, input logic [15:0] ns);
    code_start = cs;
    code_stop = ce;
    code_step = st;
    samples = ns;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
    chk(tag, busy, 0);
    @(negedge clk);
  endtask
  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask
  initial begin
    int b, d, w, cnt;
    logic stable;
    logic [15:0] c0, h0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {busy, dac_wre, stb_req, res_valid, done, err}, 0);
    chk("rst_data", {dac_code, res_code, res_hits}, 0);
    rst = 1'b0;
    @(negedge clk);
    b = q.size(); d = n_done; w = n_wre;
    sweep(16'h1000, 16'h1008, 16'd4, 16'd8);
    chk("t1_busy", busy, 1);
    wait_idle("t1_idle");
    chk("t1_nres", q.size() - b, 3);
    chk("t1_r0", q[b], {16'h1000, 16'd4});
    chk("t1_r1", q[b+1], {16'h1004, 16'd4});
    chk("t1_r2", q[b+2], {16'h1008, 16'd4});
    chk("t1_done", n_done - d, 1);
    chk("t1_wre", n_wre - w, 3);
    chk("t1_err", err, 0);
    chk("t1_dac", dac_code, 16'h1008);
    w = n_wre;
    sweep(16'h0, 16'h10, 16'd0, 16'd4);
    chk("t2a_err", err, 1);
    chk("t2a_busy", busy, 0);
    b = q.size(); d = n_done;
    sweep(16'hFFF0, 16'hFFFF, 16'h10, 16'd2);
    chk("t3_errclr", err, 0);
    wait_idle("t3_idle");
    chk("t3_nres", q.size() - b, 1);
    chk("t3_r0", q[b], {16'hFFF0, 16'd1});
    chk("t3_done", n_done - d, 1);
    w = n_wre;
    sweep(16'h20, 16'h10, 16'd1, 16'd4);
    chk("t2b_err", err, 1);
    chk("t2b_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("t2b_wre", n_wre - w, 0);
    abort = 1'b1;
    sweep(16'h0, 16'h0, 16'd1, 16'd2);
    abort = 1'b0;
    chk("sa_busy", busy, 1);
    chk("sa_err", err, 0);
    pulse_abort();
    chk("sa_abort", busy, 0);
    sweep(16'h0, 16'h10, 16'd1, 16'd0);
    chk("t2c_err", err, 1);
    chk("t2c_busy", busy, 0);
    @(negedge clk);
    res_rdy = 1'b0;
    b = q.size();
    sweep(16'h0, 16'h8, 16'd8, 16'd2);
    for (int i = 0; i < 2000 && !res_valid; i++) @(negedge clk);
    chk("t4_valid", res_valid, 1);
    c0 = res_code; h0 = res_hits; w = n_wre; stable = 1'b1;
    chk("t4_code", {c0, h0}, {16'h0, 16'd1});
    repeat (50) begin
      @(negedge clk);
      if (!res_valid || res_code !== c0 || res_hits !== h0) stable = 1'b0;
    end
    chk("t4_stable", stable, 1);
    chk("t4_nowre", n_wre - w, 0);
    res_rdy = 1'b1;
    wait_idle("t4_idle");
    chk("t4_wre", n_wre - w, 1);
    chk("t4_nres", q.size() - b, 2);
    chk("t4_r1", q[b+1], {16'h8, 16'd1});
    stb_en = 1'b0;
    d = n_done;
    sweep(16'h40, 16'h40, 16'd1, 16'd1);
    for (int i = 0; i < 200 && !stb_req; i++) @(negedge clk);
    chk("t5_req", stb_req, 1);
    cnt = 0;
    for (int i = 0; i < 300 && busy; i++) begin
      @(negedge clk);
      cnt++;
    end
    chk("t5_cyc", cnt, 100);
    chk("t5_err", err, 1);
    chk("t5_req0", stb_req, 0);
    @(negedge clk);
    chk("t5_done", n_done - d, 0);
    stb_en = 1'b1;
    d = n_done;
    sweep(16'h0, 16'h4, 16'd1, 16'd2);
    chk("t6a_err", err, 0);
    for (int i = 0; i < 200 && !dac_wre; i++) @(negedge clk);
    chk("t6a_wre", dac_wre, 1);
    repeat (6) @(negedge clk);
    chk("t6a_settle", {busy, stb_req}, 2'b10);
    pulse_abort();
    chk("t6a_outs", {busy, stb_req, res_valid, done, err}, 0);
    sweep(16'h0, 16'h4, 16'd1, 16'd2);
    for (int i = 0; i < 200 && !stb_req; i++) @(negedge clk);
    chk("t6b_req", stb_req, 1);
    pulse_abort();
    chk("t6b_outs", {busy, stb_req, res_valid, done, err}, 0);
    @(negedge clk);
    chk("t6_nodone", n_done - d, 0);
    res_rdy = 1'b0;
    b = q.size();
    sweep(16'h0, 16'h4, 16'd1, 16'd2);
    for (int i = 0; i < 2000 && !res_valid; i++) @(negedge clk);
    chk("t6c_valid", res_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6c_outs", {busy, dac_wre, stb_req, res_valid, done, err, dac_code, res_code, res_hits}, 0);
    rst = 1'b0;
    res_rdy = 1'b1;
    @(negedge clk);
    chk("t6c_nres", q.size() - b, 0);
    d = n_done;
    sweep(16'h1000, 16'h1008, 16'd4, 16'd8);
    wait_idle("t6d_idle");
    chk("t6d_nres", q.size() - b, 3);
    chk("t6d_r2", q[b+2], {16'h1008, 16'd4});
    chk("t6d_done", n_done - d, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
